// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: single-issue execute controller wrapped around a registered ALU.
// Reads operands from a local register file, issues them to the ALU, then writes the result back.
module alu_issue_ctrl #(
    parameter int  NREGS = 16,
    parameter int  W     = 32,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [3:0]    instr_funct,
    input  logic [AW-1:0] instr_rd,
    input  logic [AW-1:0] instr_rs,
    input  logic [AW-1:0] instr_rt,
    input  logic [4:0]    instr_shamt,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [W-1:0]  ld_data,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic [4:0]    alu_shamt,
    output logic [3:0]    alu_funct,
    input  logic [W-1:0]  alu_out,
    output logic          wb_valid,
    output logic [AW-1:0] wb_rd,
    output logic [W-1:0]  wb_data,
    output logic          illegal,
    input  logic [AW-1:0] dbg_addr,
    output logic [W-1:0]  dbg_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] rd_q;
    logic [W-1:0]  regs [NREGS];
    logic          accept, legal, issue, wb_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (issue) state_nxt = ISSUE;
            ISSUE:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        instr_ready = (state == IDLE);
        accept      = instr_valid && instr_ready;
        legal       = (instr_funct <= 4'd8);
        issue       = accept && legal;
        wb_fire     = (state == CAPTURE);
    end

    // Operands sample the pre-edge register file, so a same-edge ld is not forwarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_funct <= '0;
            alu_shamt <= '0;
            rd_q      <= '0;
        end else if (issue) begin
            alu_a     <= regs[instr_rs];
            alu_b     <= regs[instr_rt];
            alu_funct <= instr_funct;
            alu_shamt <= instr_shamt;
            rd_q      <= instr_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            illegal  <= 1'b0;
        end else begin
            wb_valid <= wb_fire;
            illegal  <= accept && !legal;
            if (wb_fire) begin
                wb_rd   <= rd_q;
                wb_data <= alu_out;
            end
        end
    end

    // R0 is never written after reset, so it reads as zero everywhere.
    // Write-back is the later assignment and therefore wins over ld on a collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            if (ld_en && ld_addr != '0) regs[ld_addr] <= ld_data;
            if (wb_fire && rd_q != '0)  regs[rd_q]    <= alu_out;
        end
    end

    assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: a small clocked ALU closes the loop, expected results are hand-computed.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  instr_funct, instr_rd, instr_rs, instr_rt;
    logic [4:0]  instr_shamt;
    logic        ld_en;
    logic [3:0]  ld_addr;
    logic [31:0] ld_data;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [4:0]  alu_shamt;
    logic [3:0]  alu_funct;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal;
    logic [3:0]  dbg_addr;
    logic [31:0] dbg_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.NREGS(16), .W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_funct(instr_funct), .instr_rd(instr_rd), .instr_rs(instr_rs),
        .instr_rt(instr_rt), .instr_shamt(instr_shamt),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt), .alu_funct(alu_funct),
        .alu_out(alu_out),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .illegal(illegal),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Registered ALU stand-in.
    always_ff @(posedge clk) begin
        case (alu_funct)
            4'd0:    alu_out <= alu_a + alu_b;
            4'd1:    alu_out <= alu_a - alu_b;
            4'd2:    alu_out <= alu_a & alu_b;
            4'd3:    alu_out <= alu_a | alu_b;
            4'd4:    alu_out <= alu_a ^ alu_b;
            4'd5:    alu_out <= ~alu_a;
            4'd6:    alu_out <= alu_a <<< alu_shamt;
            4'd7:    alu_out <= $signed(alu_a) >>> alu_shamt;
            4'd8:    alu_out <= alu_a >> alu_shamt;
            default: alu_out <= '0;
        endcase
    end

    typedef struct {
        logic [3:0]         funct;
        logic [3:0]         rd;
        logic [3:0]         rs;
        logic [3:0]         rt;
        logic [4:0]         shamt;
        logic signed [31:0] exp;
        bit                 clash;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Starts and ends just after a falling edge.
    task automatic ld(input logic [3:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic run_instr(input vec_t v);
        dbg_addr    = v.rd;
        instr_valid = 1'b1;
        instr_funct = v.funct; instr_rd = v.rd; instr_rs = v.rs; instr_rt = v.rt;
        instr_shamt = v.shamt;
        chk("ready_before_accept", 32'(instr_ready), 32'd1);
        @(negedge clk);
        // Busy: hold valid with junk fields, which must be ignored.
        instr_funct = 4'd12; instr_rd = 4'd15;
        chk("ready_issue", 32'(instr_ready), 32'd0);
        chk("wb_valid_issue", 32'(wb_valid), 32'd0);
        chk("alu_funct_issued", 32'(alu_funct), 32'(v.funct));
        chk("alu_shamt_issued", 32'(alu_shamt), 32'(v.shamt));
        @(negedge clk);
        instr_valid = 1'b0;
        chk("ready_capture", 32'(instr_ready), 32'd0);
        chk("wb_valid_capture", 32'(wb_valid), 32'd0);
        chk("illegal_busy", 32'(illegal), 32'd0);
        if (v.clash) begin
            ld_en = 1'b1; ld_addr = v.rd; ld_data = 32'h0BAD_F00D;
        end
        @(negedge clk);
        ld_en = 1'b0;
        chk("wb_valid", 32'(wb_valid), 32'd1);
        chk("ready_after_wb", 32'(instr_ready), 32'd1);
        chk("wb_rd", 32'(wb_rd), 32'(v.rd));
        chk("wb_data", wb_data, v.exp);
        chk("dbg_rd", dbg_data, (v.rd == 4'd0) ? 32'd0 : v.exp);
    endtask

    initial begin
        tbl[0]  = '{4'd0, 4'd3,  4'd1, 4'd2, 5'd0,  -32'sd17, 1'b0}; // ADD
        tbl[1]  = '{4'd1, 4'd6,  4'd1, 4'd2, 5'd0,  -32'sd23, 1'b0}; // SUB
        tbl[2]  = '{4'd2, 4'd7,  4'd1, 4'd2, 5'd0,  32'sd0,   1'b0}; // AND
        tbl[3]  = '{4'd3, 4'd8,  4'd1, 4'd2, 5'd0,  -32'sd17, 1'b0}; // OR
        tbl[4]  = '{4'd4, 4'd9,  4'd1, 4'd2, 5'd0,  -32'sd17, 1'b0}; // XOR
        tbl[5]  = '{4'd5, 4'd10, 4'd1, 4'd2, 5'd0,  32'sd19,  1'b0}; // NOT
        tbl[6]  = '{4'd7, 4'd11, 4'd1, 4'd2, 5'd2,  -32'sd5,  1'b0}; // SRA 2
        tbl[7]  = '{4'd6, 4'd12, 4'd1, 4'd2, 5'd0,  -32'sd20, 1'b0}; // SLA 0
        tbl[8]  = '{4'd0, 4'd5,  4'd3, 4'd2, 5'd0,  -32'sd14, 1'b0}; // dependent on R3
        tbl[9]  = '{4'd0, 4'd0,  4'd1, 4'd2, 5'd0,  -32'sd17, 1'b0}; // write-back to R0
        tbl[10] = '{4'd0, 4'd4,  4'd1, 4'd2, 5'd0,  -32'sd17, 1'b1}; // ld collides on R4
        tbl[11] = '{4'd8, 4'd13, 4'd1, 4'd2, 5'd28, 32'sd15,  1'b0}; // SRL 28

        rst_n = 1'b0; instr_valid = 1'b0;
        instr_funct = '0; instr_rd = '0; instr_rs = '0; instr_rt = '0; instr_shamt = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = 4'd1;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_funct", 32'(alu_funct), 32'd0);
        chk("rst_alu_shamt", 32'(alu_shamt), 32'd0);
        chk("rst_r1", dbg_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        ld(4'd1, -32'sd20);
        ld(4'd2, 32'd3);

        // Back-to-back: each entry is accepted in the cycle the previous wb_valid is high.
        for (int i = 0; i < 12; i++) run_instr(tbl[i]);

        // Illegal funct is accepted in place and leaves the ALU controls alone.
        instr_valid = 1'b1; instr_funct = 4'd12; instr_rd = 4'd14;
        instr_rs = 4'd2; instr_rt = 4'd2; instr_shamt = 5'd3;
        chk("ill_ready_pre", 32'(instr_ready), 32'd1);
        @(negedge clk);
        instr_valid = 1'b0;
        chk("ill_pulse", 32'(illegal), 32'd1);
        chk("ill_ready", 32'(instr_ready), 32'd1);
        chk("ill_no_wb", 32'(wb_valid), 32'd0);
        chk("ill_alu_funct", 32'(alu_funct), 32'd8);
        chk("ill_alu_shamt", 32'(alu_shamt), 32'd28);
        chk("ill_alu_a", alu_a, -32'sd20);
        @(negedge clk);
        chk("ill_pulse_end", 32'(illegal), 32'd0);
        chk("ill_ready_2", 32'(instr_ready), 32'd1);
        chk("ill_no_wb_2", 32'(wb_valid), 32'd0);

        ld(4'd0, 32'd55);
        dbg_addr = 4'd0;
        #1 chk("ld_r0_dropped", dbg_data, 32'd0);
        dbg_addr = 4'd1;
        #1 chk("r1_before_reset", dbg_data, -32'sd20);

        // Reset while the instruction sits in CAPTURE.
        @(negedge clk);
        instr_valid = 1'b1; instr_funct = 4'd0; instr_rd = 4'd14;
        instr_rs = 4'd1; instr_rt = 4'd2; instr_shamt = 5'd0;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        chk("mid_in_capture", 32'(instr_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_ready", 32'(instr_ready), 32'd1);
        chk("mid_wb_valid", 32'(wb_valid), 32'd0);
        chk("mid_wb_rd", 32'(wb_rd), 32'd0);
        chk("mid_wb_data", wb_data, 32'd0);
        chk("mid_alu_a", alu_a, 32'd0);
        chk("mid_alu_b", alu_b, 32'd0);
        chk("mid_alu_funct", 32'(alu_funct), 32'd0);
        chk("mid_r1", dbg_data, 32'd0);
        @(negedge clk);
        chk("mid_wb_valid_2", 32'(wb_valid), 32'd0);
        rst_n = 1'b1;
        dbg_addr = 4'd14;
        @(negedge clk);
        chk("mid_wb_valid_3", 32'(wb_valid), 32'd0);
        chk("mid_r14", dbg_data, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
